// File: rtl/hazard_tracker_pkg.sv
// Shared types for the hazard tracker: FSM state encoding, shadow-entry layout
// and the default register-index width.
package hazard_tracker_pkg;

  localparam int unsigned HAZ_REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_WAIT = 2'd2
  } haz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [HAZ_REG_W-1:0] regd;
    logic                 regwrite;
    logic                 memread;
  } haz_entry_t;

endpackage

// File: rtl/hazard_tracker_stage_reg.sv
// One shadow pipeline entry. Clear wins over hold; hold wins over load.
module haz_stage_reg
  import hazard_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_hold,
  input  logic       i_load,
  input  haz_entry_t i_d,
  output haz_entry_t o_q
);

  haz_entry_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (!i_hold && i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight destinations through ID/EX, EX/MEM, MEM/WB and issues stall,
// bubble and flush controls. Define HAZ_STATS_EN to add saturating event counters.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_W = HAZ_REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_RegS,
  input  logic [REG_W-1:0] id_RegT,
  input  logic             id_UsesT,
  input  logic [REG_W-1:0] id_RegD,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic [REG_W-1:0] ex_m_RegD,
  output logic             ex_m_RegWrite,
  output logic [REG_W-1:0] mem_wb_RegD,
  output logic             mem_wb_RegWrite,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_id_ex,
  output logic             bubble_mem_wb,
  output logic             flush_if_id,
  output logic             mem_req,
`ifdef HAZ_STATS_EN
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       haz_state
);

  haz_state_t r_state;
  haz_state_t w_state_nxt;

  haz_entry_t w_idex_q;
  haz_entry_t w_exm_q;
  haz_entry_t w_memwb_q;
  haz_entry_t w_idex_d;

  logic w_wait;
  logic w_lu;
  logic w_branch;
  logic w_lu_act;
  logic w_br_act;

  // Hazard detection
  assign mem_req  = w_exm_q.valid & w_exm_q.memread;
  assign w_wait   = mem_req & ~mem_ready;
  assign w_branch = branch_taken & rst_n;
  assign w_lu     = id_valid & w_idex_q.valid & w_idex_q.memread & w_idex_q.regwrite
                  & (w_idex_q.regd != '0)
                  & ((w_idex_q.regd == id_RegS) | (id_UsesT & (w_idex_q.regd == id_RegT)));

  assign w_br_act = w_branch & ~w_wait;
  assign w_lu_act = w_lu & ~w_wait & ~w_branch;

  always_comb begin
    w_idex_d          = '0;
    w_idex_d.valid    = id_valid;
    w_idex_d.regd     = id_RegD;
    w_idex_d.regwrite = id_RegWrite & (id_RegD != '0);
    w_idex_d.memread  = id_MemRead;
  end

  haz_stage_reg u_idex (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_br_act | w_lu_act),
    .i_hold  (w_wait),
    .i_load  (1'b1),
    .i_d     (w_idex_d),
    .o_q     (w_idex_q)
  );

  haz_stage_reg u_exm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (1'b0),
    .i_hold  (w_wait),
    .i_load  (1'b1),
    .i_d     (w_idex_q),
    .o_q     (w_exm_q)
  );

  haz_stage_reg u_memwb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_wait),
    .i_hold  (1'b0),
    .i_load  (1'b1),
    .i_d     (w_exm_q),
    .o_q     (w_memwb_q)
  );

  assign ex_m_RegD       = w_exm_q.regd;
  assign ex_m_RegWrite   = w_exm_q.valid & w_exm_q.regwrite;
  assign mem_wb_RegD     = w_memwb_q.regd;
  assign mem_wb_RegWrite = w_memwb_q.valid & w_memwb_q.regwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_wait) begin
      w_state_nxt = ST_WAIT;
    end else if (w_lu) begin
      w_state_nxt = ST_LU;
    end
  end

  always_comb begin
    stall_if_id   = w_wait | w_lu_act;
    stall_id_ex   = w_wait;
    bubble_id_ex  = w_br_act | w_lu_act;
    bubble_mem_wb = w_wait;
    flush_if_id   = w_br_act;
    haz_state     = r_state;
  end

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt    <= '0;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu_act && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + 1'b1;
      end
      if (w_wait && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_br_act && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign lu_stall_cnt = r_lu_cnt;
  assign mem_wait_cnt = r_wait_cnt;
  assign flush_cnt    = r_flush_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the pipeline.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_RegS = '0;
  logic [4:0] id_RegT = '0;
  logic       id_UsesT = 1'b0;
  logic [4:0] id_RegD = '0;
  logic       id_RegWrite = 1'b0;
  logic       id_MemRead = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic [4:0] ex_m_RegD;
  logic       ex_m_RegWrite;
  logic [4:0] mem_wb_RegD;
  logic       mem_wb_RegWrite;
  logic       stall_if_id;
  logic       stall_id_ex;
  logic       bubble_id_ex;
  logic       bubble_mem_wb;
  logic       flush_if_id;
  logic       mem_req;
  logic [1:0] haz_state;
`ifdef HAZ_STATS_EN
  logic [15:0] lu_stall_cnt;
  logic [15:0] mem_wait_cnt;
  logic [15:0] flush_cnt;
`endif

  hazard_tracker #(.REG_W(5), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_RegS         (id_RegS),
    .id_RegT         (id_RegT),
    .id_UsesT        (id_UsesT),
    .id_RegD         (id_RegD),
    .id_RegWrite     (id_RegWrite),
    .id_MemRead      (id_MemRead),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .ex_m_RegD       (ex_m_RegD),
    .ex_m_RegWrite   (ex_m_RegWrite),
    .mem_wb_RegD     (mem_wb_RegD),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .stall_if_id     (stall_if_id),
    .stall_id_ex     (stall_id_ex),
    .bubble_id_ex    (bubble_id_ex),
    .bubble_mem_wb   (bubble_mem_wb),
    .flush_if_id     (flush_if_id),
    .mem_req         (mem_req),
`ifdef HAZ_STATS_EN
    .lu_stall_cnt    (lu_stall_cnt),
    .mem_wait_cnt    (mem_wait_cnt),
    .flush_cnt       (flush_cnt),
`endif
    .haz_state       (haz_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model pipeline: slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
  logic       mv  [3];
  logic [4:0] mrd [3];
  logic       mrw [3];
  logic       mmr [3];
  int unsigned m_last_action;  // 0 run, 1 lu, 2 wait
`ifdef HAZ_STATS_EN
  int unsigned m_lu_cnt, m_wt_cnt, m_fl_cnt;
`endif

  // Observed values captured at the last checkpoint, for directed checks
  logic       g_stall_if_id, g_stall_id_ex, g_bubble_id_ex, g_bubble_mem_wb, g_flush;
  logic       g_exrw, g_mwrw;
  logic [4:0] g_exrd, g_mwrd;
  logic [1:0] g_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0; mrd[i] = '0; mrw[i] = 1'b0; mmr[i] = 1'b0;
    end
    m_last_action = 0;
`ifdef HAZ_STATS_EN
    m_lu_cnt = 0; m_wt_cnt = 0; m_fl_cnt = 0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ex_m_RegD"}, 32'(ex_m_RegD), 0);
    chk({tag, ".ex_m_RegWrite"}, 32'(ex_m_RegWrite), 0);
    chk({tag, ".mem_wb_RegD"}, 32'(mem_wb_RegD), 0);
    chk({tag, ".mem_wb_RegWrite"}, 32'(mem_wb_RegWrite), 0);
    chk({tag, ".stall_if_id"}, 32'(stall_if_id), 0);
    chk({tag, ".stall_id_ex"}, 32'(stall_id_ex), 0);
    chk({tag, ".bubble_id_ex"}, 32'(bubble_id_ex), 0);
    chk({tag, ".bubble_mem_wb"}, 32'(bubble_mem_wb), 0);
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".haz_state"}, 32'(haz_state), 0);
`ifdef HAZ_STATS_EN
    chk({tag, ".lu_stall_cnt"}, 32'(lu_stall_cnt), 0);
    chk({tag, ".mem_wait_cnt"}, 32'(mem_wait_cnt), 0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 0);
`endif
  endtask

  // One clock: drive inputs, compare outputs against the model mid-cycle, advance the model.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic br, input logic rdy);
    logic       load_pending, must_wait, load_use, do_flush, do_lu;
    id_valid = v; id_RegS = rs; id_RegT = rt; id_UsesT = ut;
    id_RegD = rd; id_RegWrite = rw; id_MemRead = mr;
    branch_taken = br; mem_ready = rdy;
    @(negedge clk);

    load_pending = mv[1] && mmr[1];
    must_wait    = load_pending && !rdy;
    load_use     = v && mv[0] && mmr[0] && mrw[0] && (mrd[0] != 0) &&
                   ((mrd[0] == rs) || (ut && (mrd[0] == rt)));
    do_flush     = br && !must_wait;
    do_lu        = load_use && !must_wait && !br;

    chk("mem_req", 32'(mem_req), 32'(load_pending));
    chk("stall_if_id", 32'(stall_if_id), 32'(must_wait || do_lu));
    chk("stall_id_ex", 32'(stall_id_ex), 32'(must_wait));
    chk("bubble_id_ex", 32'(bubble_id_ex), 32'(do_flush || do_lu));
    chk("bubble_mem_wb", 32'(bubble_mem_wb), 32'(must_wait));
    chk("flush_if_id", 32'(flush_if_id), 32'(do_flush));
    chk("ex_m_RegD", 32'(ex_m_RegD), 32'(mrd[1]));
    chk("ex_m_RegWrite", 32'(ex_m_RegWrite), 32'(mv[1] && mrw[1]));
    chk("mem_wb_RegD", 32'(mem_wb_RegD), 32'(mrd[2]));
    chk("mem_wb_RegWrite", 32'(mem_wb_RegWrite), 32'(mv[2] && mrw[2]));
    chk("haz_state", 32'(haz_state), m_last_action);
`ifdef HAZ_STATS_EN
    chk("lu_stall_cnt", 32'(lu_stall_cnt), m_lu_cnt);
    chk("mem_wait_cnt", 32'(mem_wait_cnt), m_wt_cnt);
    chk("flush_cnt", 32'(flush_cnt), m_fl_cnt);
`endif

    g_stall_if_id = stall_if_id; g_stall_id_ex = stall_id_ex;
    g_bubble_id_ex = bubble_id_ex; g_bubble_mem_wb = bubble_mem_wb;
    g_flush = flush_if_id; g_exrw = ex_m_RegWrite; g_mwrw = mem_wb_RegWrite;
    g_exrd = ex_m_RegD; g_mwrd = mem_wb_RegD; g_state = haz_state;

    @(posedge clk);
    #1;
    if (must_wait) begin
      mv[2] = 1'b0; mrd[2] = '0; mrw[2] = 1'b0; mmr[2] = 1'b0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1]; mrd[i] = mrd[i-1]; mrw[i] = mrw[i-1]; mmr[i] = mmr[i-1];
      end
      if (do_flush || do_lu) begin
        mv[0] = 1'b0; mrd[0] = '0; mrw[0] = 1'b0; mmr[0] = 1'b0;
      end else begin
        mv[0] = v; mrd[0] = rd; mrw[0] = rw && (rd != 0); mmr[0] = mr;
      end
    end
    m_last_action = must_wait ? 2 : (load_use ? 1 : 0);
`ifdef HAZ_STATS_EN
    if (do_lu && m_lu_cnt < 65535) m_lu_cnt++;
    if (must_wait && m_wt_cnt < 65535) m_wt_cnt++;
    if (do_flush && m_fl_cnt < 65535) m_fl_cnt++;
`endif
  endtask

  task automatic nop(input logic rdy = 1'b1, input logic br = 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    branch_taken = 1'b0;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add r3 flows through EX/MEM then MEM/WB with no stalls
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("add.no_stall", 32'(g_stall_if_id), 0);
    nop();
    nop();
    chk("add.exm_rd", 32'(g_exrd), 3);
    chk("add.exm_rw", 32'(g_exrw), 1);
    nop();
    chk("add.memwb_rd", 32'(g_mwrd), 3);
    chk("add.memwb_rw", 32'(g_mwrw), 1);

    // lw r5 then add r6,r5,r2: one stall cycle, add re-presented
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu.stall_if_id", 32'(g_stall_if_id), 1);
    chk("lu.bubble_id_ex", 32'(g_bubble_id_ex), 1);
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu.one_cycle", 32'(g_stall_if_id), 0);
    chk("lu.haz_state", 32'(g_state), 1);
    nop();
    nop();
    chk("lu.add_late", 32'(g_exrd), 6);

    // lw r5 with mem_ready low for three cycles
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    nop();
    for (int i = 0; i < 3; i++) begin
      nop(1'b0);
      chk("wait.stall_id_ex", 32'(g_stall_id_ex), 1);
      chk("wait.memwb_rw", 32'(g_mwrw), 0);
      chk("wait.exm_hold", 32'(g_exrd), 5);
      if (i > 0) chk("wait.haz_state", 32'(g_state), 2);
    end
    nop();
    chk("wait.released", 32'(g_stall_id_ex), 0);
    nop();
    nop();

    // branch and load-use in the same cycle: branch wins
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 5'd7, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("brlu.flush", 32'(g_flush), 1);
    chk("brlu.bubble", 32'(g_bubble_id_ex), 1);
    chk("brlu.no_stall", 32'(g_stall_if_id), 0);
    nop();
    nop();

    // branch during a memory wait: flush only once unfrozen
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    nop();
    nop(1'b0, 1'b1);
    chk("brwait.no_flush", 32'(g_flush), 0);
    nop(1'b0, 1'b1);
    chk("brwait.no_flush2", 32'(g_flush), 0);
    nop(1'b1, 1'b1);
    chk("brwait.flush", 32'(g_flush), 1);
    nop();
    nop();

    // asynchronous reset in the middle of a wait
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    nop();
    nop(1'b0);
    id_valid = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    do_reset();
    nop();

    // r0 destination never raises RegWrite
    cyc(1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    nop();
    nop();
    chk("r0.exm_rw", 32'(g_exrw), 0);
    chk("r0.exm_rd", 32'(g_exrd), 0);
    nop();
    chk("r0.memwb_rw", 32'(g_mwrw), 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 4) != 0),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
